// File: rtl/seq_mult.sv
// Unsigned NxN shift-and-add multiplier, one rca_ iteration per cycle.
// Includes the rca_ ripple-carry adder it drives.
module rca_ #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         c
);
  logic [N:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) |
                     (cy[i] & (a[i] ^ b[i]));
  end

  assign c = cy[N];
endmodule

module seq_mult #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   p_q, p_d;

  logic [N-1:0]     add_b;
  logic [N-1:0]     sum;
  logic             cout;

  // Partial product only adds M when the multiplier LSB is set
  assign add_b = q_q[0] ? m_q : '0;

  rca_ #(.N(N)) u_rca (
    .a   (acc_q),
    .b   (add_b),
    .cin (1'b0),
    .s   (sum),
    .c   (cout)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        {acc_d, q_d} = {cout, sum, q_q[N-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          p_d     = {acc_d, q_d};
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign p    = p_q;
endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomized checks of seq_mult against a plain a*b model.
module tb_seq_mult;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  int errors;
  int checks;

  seq_mult #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input int x, input int y);
    int prod;
    prod = x * y;
    return (2*N)'(prod);
  endfunction

  // One operation; with noise, start/a/b churn during BUSY and DONE
  task automatic do_op(input int x, input int y, input bit noise);
    logic [2*N-1:0] exp;
    int bc;
    exp = model(x, y);
    @(negedge clk);
    start = 1'b1;
    a = N'(x);
    b = N'(y);
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    for (int k = 0; k < N; k++) begin
      if (noise) begin
        start = 1'($urandom);
        a = N'($urandom);
        b = N'($urandom);
      end
      if (busy === 1'b1 && done === 1'b0) bc++;
      @(negedge clk);
    end
    start = noise;
    if (noise) begin
      a = N'($urandom);
      b = N'($urandom);
    end
    chk("busy_cycles", 64'(bc), 64'(N));
    chk("done_hi", 64'(done), 64'd1);
    chk("p_at_done", 64'(p), 64'(exp));
    @(negedge clk);
    start = 1'b0;
    chk("idle_after", 64'({busy, done}), 64'd0);
    chk("p_hold", 64'(p), 64'(exp));
  endtask

  initial begin
    int last;
    int ndone;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    rst_n = 1'b1;

    do_op(3, 5, 1'b0);
    do_op(15, 15, 1'b0);
    do_op(0, 9, 1'b0);
    do_op(9, 0, 1'b0);
    do_op(11, 13, 1'b1);
    do_op(7, 14, 1'b1);

    // Continuous start: one result every N+2 cycles
    @(negedge clk);
    start = 1'b1;
    a = N'(6);
    b = N'(7);
    last = -1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        chk("hold_p", 64'(p), 64'd42);
        if (last >= 0) chk("hold_gap", 64'(i - last), 64'(N + 2));
        last = i;
      end
    end
    start = 1'b0;
    chk("hold_count", 64'(ndone), 64'd3);
    repeat (N + 3) @(negedge clk);

    // Async reset inside the second iteration
    do_op(9, 13, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = N'(5);
    b = N'(11);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_p", 64'(p), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) ndone++;
    end
    chk("arst_quiet", 64'(ndone), 64'd0);
    chk("arst_p_after", 64'(p), 64'd0);
    do_op(5, 11, 1'b0);

    // Exhaustive over N=4 operand space
    for (int x = 0; x < (1 << N); x++)
      for (int y = 0; y < (1 << N); y++)
        do_op(x, y, 1'b0);

    // Random operands with input churn
    for (int r = 0; r < 200; r++)
      do_op(int'($urandom_range((1 << N) - 1)),
            int'($urandom_range((1 << N) - 1)),
            1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
